// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core among N_REQ byte producers.
// It sequences grant, start pulse and busy/done tracking, then enforces an idle gap with a busy-ack watchdog.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int GAP_CLKS     = 521,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [ID_W-1:0]      cur_id,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  localparam int CNT_MAX = (GAP_CLKS > BUSY_TIMEOUT) ? GAP_CLKS : BUSY_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CLKS);
  localparam logic [CNT_W-1:0] BUSY_END = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  // A zero-length gap skips the GAP state entirely.
  localparam state_t AFTER_FRAME = (GAP_CLKS == 0) ? IDLE : GAP;

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n, sel;
  logic              found;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [N_REQ-1:0]  gnt_n;
  logic              start_n, err_n, load;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the far end so the offset closest to ptr is the one that sticks.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr, i)]) begin
        sel   = wrap_add(ptr, i);
        found = 1'b1;
      end
    end
  end

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    ptr_n   = ptr;
    gnt_n   = '0;
    start_n = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (found) begin
          gnt_n[sel] = 1'b1;
          start_n    = 1'b1;
          load       = 1'b1;
          ptr_n      = wrap_add(sel, 1);
          state_n    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_done) begin
          state_n = AFTER_FRAME;
          cnt_n   = '0;
        end else if (tx_busy) begin
          state_n = WAIT_DONE;
          cnt_n   = '0;
        end else if (cnt_inc >= BUSY_END) begin
          err_n   = 1'b1;
          state_n = AFTER_FRAME;
          cnt_n   = '0;
        end
      end
      WAIT_DONE: begin
        // A busy drop without a done pulse still ends the frame.
        if (tx_done || !tx_busy) begin
          state_n = AFTER_FRAME;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt_inc >= GAP_END) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      cur_id      <= '0;
      arb_busy    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      gnt         <= gnt_n;
      tx_start    <= start_n;
      err_timeout <= err_n;
      arb_busy    <= (state_n != IDLE);
      if (load) begin
        tx_data <= req_data[8*sel +: 8];
        cur_id  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a behavioural TX core and line receiver,
// a grant scoreboard, a round-robin vector table and hand-written timing sequences.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int ID_W         = 2;
  localparam int GAP_CLKS     = 521;
  localparam int BUSY_TIMEOUT = 16;

  logic                 tx_clk = 1'b0;
  logic                 tx_rst_n;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     gnt;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [ID_W-1:0]      cur_id;
  logic                 arb_busy;
  logic                 err_timeout;

  always #5 tx_clk = ~tx_clk;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .GAP_CLKS(GAP_CLKS), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .cur_id(cur_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [7:0] exp_data;
    logic [1:0] exp_id;
  } vec_t;

  typedef enum int {CORE_NORMAL, CORE_SILENT, CORE_FAST} core_mode_t;

  int         checks = 0;
  int         errors = 0;
  int         gnt_seen = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[11];
  core_mode_t core_mode;
  int         bit_clks;
  logic       line;
  logic [9:0] core_frame;
  logic [7:0] rx_byte;
  logic [7:0] rx_got[$];
  int         n, lows, errs, err_at, g0, k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_gnt(input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(negedge tx_clk);
      c++;
    end while (gnt == '0 && c < budget);
    if (gnt == '0) fail_now(name);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge tx_clk);
      c++;
    end while (arb_busy && c < budget);
    if (arb_busy) fail_now("wait_idle");
  endtask

  // Counts cycles from a tx_done pulse to the next tx_start; lows counts arb_busy=0 inside the gap.
  task automatic measure_gap(output int cyc, output int low_cnt, input core_mode_t next_mode);
    int c;
    c = 0;
    cyc = 0;
    low_cnt = 0;
    do begin
      @(negedge tx_clk);
      c++;
    end while (!tx_done && c < 20000);
    if (!tx_done) begin
      fail_now("gap_done_wait");
    end else begin
      core_mode = next_mode;
      do begin
        @(negedge tx_clk);
        cyc++;
        if (cyc <= GAP_CLKS && !arb_busy) low_cnt++;
      end while (!tx_start && cyc < 2000);
    end
  endtask

  // Scoreboard monitor: every grant must match the oldest outstanding expectation.
  always @(negedge tx_clk) begin
    if (tx_rst_n && (gnt != '0 || tx_start)) begin
      gnt_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: gnt=%b tx_start=%b, no grant expected", gnt, tx_start);
      end else begin
        mon_e = sb.pop_front();
        check("grant", {gnt, tx_start, tx_data, cur_id}, {mon_e.gnt, 1'b1, mon_e.data, mon_e.id});
      end
    end
  end

  // Behavioural TX core: 8N1 serialiser with bit_clks clocks per bit.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    line    = 1'b1;
    forever begin
      @(negedge tx_clk);
      if (tx_start) begin
        case (core_mode)
          CORE_NORMAL: begin
            core_frame = {1'b1, tx_data, 1'b0};
            tx_busy = 1'b1;
            for (int b = 0; b < 10; b++) begin
              line = core_frame[b];
              repeat (bit_clks) @(negedge tx_clk);
            end
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(negedge tx_clk);
            tx_done = 1'b0;
          end
          CORE_FAST: begin
            repeat (2) @(negedge tx_clk);
            tx_busy = 1'b1;
            tx_done = 1'b1;
            @(negedge tx_clk);
            tx_busy = 1'b0;
            tx_done = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Line receiver sampling at bit centres.
  initial begin
    forever begin
      @(negedge tx_clk);
      if (line == 1'b0) begin
        repeat (bit_clks / 2) @(negedge tx_clk);
        for (int b = 0; b < 8; b++) begin
          repeat (bit_clks) @(negedge tx_clk);
          rx_byte[b] = line;
        end
        repeat (bit_clks) @(negedge tx_clk);
        rx_got.push_back(rx_byte);
      end
    end
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 8'hA0, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0010, 8'hA1, 2'd1};
    vecs[2]  = '{4'b1111, 4'b0100, 8'hA2, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1000, 8'hA3, 2'd3};
    vecs[4]  = '{4'b1111, 4'b0001, 8'hA0, 2'd0};
    vecs[5]  = '{4'b1111, 4'b0010, 8'hA1, 2'd1};
    vecs[6]  = '{4'b1111, 4'b0100, 8'hA2, 2'd2};
    vecs[7]  = '{4'b1111, 4'b1000, 8'hA3, 2'd3};
    vecs[8]  = '{4'b0110, 4'b0010, 8'hA1, 2'd1};
    vecs[9]  = '{4'b0110, 4'b0100, 8'hA2, 2'd2};
    vecs[10] = '{4'b0001, 4'b0001, 8'hA0, 2'd0};

    core_mode = CORE_NORMAL;
    bit_clks  = 521;
    req       = '0;
    req_data  = {8'hA3, 8'hE3, 8'hA1, 8'hA0};
    tx_rst_n  = 1'b0;
    repeat (3) @(negedge tx_clk);
    check("reset_outputs", {gnt, tx_start, tx_data, cur_id, arb_busy, err_timeout}, '0);

    // Single request, full-rate line, one-cycle grant latency.
    tx_rst_n = 1'b1;
    req = 4'b0100;
    sb.push_back('{4'b0100, 8'hE3, 2'd2});
    @(negedge tx_clk);
    check("single_latency_gnt", gnt, 4'b0100);
    check("single_arb_busy", arb_busy, 1);
    req = '0;
    k = 0;
    while (rx_got.size() == 0 && k < 12000) begin
      @(negedge tx_clk);
      k++;
    end
    if (rx_got.size() == 0) fail_now("rx_byte");
    else check("rx_byte", rx_got.pop_front(), 8'hE3);
    wait_idle(2000);

    // Round-robin fairness, pointer wrap and skip, with a short bit time.
    bit_clks = 4;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tx_rst_n = 1'b0;
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    for (int v = 0; v < 11; v++) begin
      req = vecs[v].req;
      sb.push_back('{vecs[v].exp_gnt, vecs[v].exp_data, vecs[v].exp_id});
      wait_gnt(2000, "rr_grant_wait");
    end

    // Gap spacing after a normal frame, then after a done+busy same-cycle fast core.
    req = 4'b0011;
    sb.push_back('{4'b0010, 8'hA1, 2'd1});
    wait_gnt(2000, "gap_first_grant");
    sb.push_back('{4'b0001, 8'hA0, 2'd0});
    measure_gap(n, lows, CORE_FAST);
    check("gap_spacing", n, GAP_CLKS + 2);
    check("gap_arb_busy_low", lows, 0);
    sb.push_back('{4'b0010, 8'hA1, 2'd1});
    measure_gap(n, lows, CORE_NORMAL);
    check("gap_spacing_fast_done", n, GAP_CLKS + 2);
    req = '0;

    // Watchdog: silent core, then the held request is granted again with a new byte.
    wait_idle(2000);
    core_mode = CORE_SILENT;
    req = 4'b0100;
    sb.push_back('{4'b0100, 8'hA2, 2'd2});
    wait_gnt(100, "timeout_grant");
    n = 0;
    errs = 0;
    err_at = 0;
    do begin
      @(negedge tx_clk);
      n++;
      if (n == 1) begin
        core_mode = CORE_NORMAL;
        req_data[23:16] = 8'h5C;
        sb.push_back('{4'b0100, 8'h5C, 2'd2});
      end
      if (err_timeout) begin
        errs++;
        if (err_at == 0) err_at = n;
      end
    end while (!tx_start && n < 2000);
    check("timeout_delay", err_at, BUSY_TIMEOUT);
    check("timeout_pulse_count", errs, 1);
    check("timeout_regrant_delay", n, BUSY_TIMEOUT + GAP_CLKS + 1);
    req = '0;

    // Reset during WAIT_DONE clears outputs and the round-robin pointer.
    wait_idle(2000);
    req = 4'b0010;
    sb.push_back('{4'b0010, 8'hA1, 2'd1});
    wait_gnt(100, "midframe_grant");
    repeat (3) @(negedge tx_clk);
    tx_rst_n = 1'b0;
    req = 4'b1111;
    @(negedge tx_clk);
    check("reset_midframe_outputs", {gnt, tx_start, tx_data, cur_id, arb_busy, err_timeout}, '0);
    sb.push_back('{4'b0001, 8'hA0, 2'd0});
    tx_rst_n = 1'b1;
    wait_gnt(100, "reset_ptr_grant");
    req = '0;

    // A request raised and dropped inside the gap is never granted.
    k = 0;
    do begin
      @(negedge tx_clk);
      k++;
    end while (!tx_done && k < 200);
    if (!tx_done) fail_now("withdraw_done_wait");
    repeat (5) @(negedge tx_clk);
    req = 4'b0001;
    repeat (3) @(negedge tx_clk);
    req = '0;
    g0 = gnt_seen;
    repeat (700) @(negedge tx_clk);
    check("withdrawn_no_grant", gnt_seen, g0);
    check("withdrawn_idle", arb_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter core among N_REQ byte-producing requesters using round-robin arbitration. It sequences each frame: grant, start pulse, busy/done tracking, then an enforced inter-frame idle gap. It sits between client logic and the UART TX core, which runs at CLKS_PER_BIT = 521, i.e. 19200 baud from a 10 MHz clock. It also provides a watchdog for a core that never acknowledges a start.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of cur_id; must satisfy 2**ID_W >= N_REQ
GAP_CLKS, 521, idle clocks enforced after each frame ends (0 = no gap)
BUSY_TIMEOUT, 16, clocks to wait for tx_busy after tx_start before abort

Ports:
tx_clk  in  1  single clock; all logic on rising edge
tx_rst_n  in  1  reset, synchronous, active-low
req  in  N_REQ  per-requester byte-pending request; level
req_data  in  8*N_REQ  requester i byte at bits [8i+7:8i]
gnt  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_start  out  1  one-cycle start pulse to TX core
tx_data  out  8  byte to TX core; held stable from tx_start until frame end
tx_busy  in  1  TX core frame in progress
tx_done  in  1  TX core one-cycle end-of-frame pulse
cur_id  out  ID_W  index of the requester owning the current or last frame
arb_busy  out  1  high whenever state != IDLE
err_timeout  out  1  one-cycle pulse: tx_busy not seen within BUSY_TIMEOUT

Behaviour:
- Reset (tx_rst_n=0 at an edge): state=IDLE, gnt=0, tx_start=0, tx_data=0, cur_id=0, arb_busy=0, err_timeout=0, rr pointer=0, counters=0. This applies even mid-frame. The in-flight frame is abandoned. Its byte counts as consumed because gnt was already issued.
- All outputs are registered.
- IDLE: when any req bit is set, select the first set index scanning ptr, ptr+1, ... with modulo N_REQ wrap.
- On the next edge after selection: gnt[sel]=1, tx_start=1, tx_data=req_data[sel], cur_id=sel, ptr=(sel+1) mod N_REQ, then go to WAIT_BUSY.
- Latency: req sampled at edge k gives gnt/tx_start high during cycle k+1.
- Requester handshake: req and data must stay stable until gnt. Dropping req before gnt withdraws the request with no side effect. After gnt, the requester may keep req high with a new byte; that byte competes at the next IDLE arbitration.
- WAIT_BUSY: the timeout counter counts from tx_start.
  - tx_busy=1 goes to WAIT_DONE.
  - tx_done=1 (fast core), including tx_done and tx_busy in the same cycle, goes to GAP; tx_done has priority.
  - Counter reaching BUSY_TIMEOUT with neither seen: err_timeout=1 for one cycle, then go to GAP.
- WAIT_DONE: tx_done=1 goes to GAP. A falling tx_busy without tx_done is also treated as frame end and goes to GAP.
- GAP: counts GAP_CLKS cycles, then goes to IDLE. With GAP_CLKS=0, go directly to IDLE.
- Minimum spacing: tx_done to the next tx_start is exactly GAP_CLKS+2 cycles when a req is already pending.
- tx_data and cur_id hold their values until the next grant.
- Only one gnt bit is ever high, never more than one per frame. tx_start is never reissued within a frame.
- req bits that change during non-IDLE states are ignored until IDLE.
- The counter width covers max(GAP_CLKS, BUSY_TIMEOUT). Counters saturate and never wrap.

Test Plan:
- Single request: from reset, req=4'b0100, req_data[23:16]=8'hE3 -> one cycle later gnt=4'b0100, tx_start=1, tx_data=8'hE3, cur_id=2, arb_busy=1. A model TX core (CLKS_PER_BIT=521) serialises 0xE3 and a uart_rx on its line reports 8'hE3.
- Round-robin fairness: req=4'b1111 held, each requester's data = 8'hA0+i -> grant order 0,1,2,3,0,1; tx_data sequence A0,A1,A2,A3,A0.
- Pointer wrap and skip: after a grant to 3, set req=4'b0110 -> next grant is 1, then 2. Now req=4'b0001 -> grant 0.
- Gap timing: GAP_CLKS=521, req pending, tx_done pulse at cycle t -> next tx_start at t+523 exactly; arb_busy stays high throughout.
- Timeout: model holds tx_busy=0 and tx_done=0 after tx_start -> err_timeout pulse 16 cycles after tx_start, GAP entered, next pending req granted afterwards.
- Reset mid-frame and withdrawal: assert tx_rst_n=0 during WAIT_DONE -> all outputs 0 next edge, ptr=0. Separately, req pulse dropped while in GAP -> no gnt for that requester.
